// File: rtl/led_strip_serializer.sv
// led_strip_serializer
// Drives one WS2812-style single-wire LED strip from a packed slice of 6-bit
// LED codes. A START request snapshots the slice into a shadow register. Each
// code is expanded to 24-bit GRB and shifted out MSB first, using pulse-width
// bit encoding. The line is then held low for the latch interval, and DONE
// pulses once.

module led_strip_serializer #(
  parameter int N_LEDS       = 32,
  parameter int T_BIT        = 125,
  parameter int T0H          = 40,
  parameter int T1H          = 80,
  parameter int RESET_CYCLES = 8000
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [N_LEDS*6-1:0]   LED_DATA,
  input  logic                  START,
  output logic                  LED_DOUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVERRUN
);

  // One shared cycle counter times both the bit slots and the latch interval,
  // so it is sized for whichever of the two is longer.
  localparam int CNT_MAX = (T_BIT > RESET_CYCLES) ? T_BIT : RESET_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int LW      = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  localparam logic [CW-1:0] CYC_BIT_LAST   = CW'(T_BIT - 1);
  localparam logic [CW-1:0] CYC_LATCH_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_T0        = CW'(T0H);
  localparam logic [CW-1:0] HIGH_T1        = CW'(T1H);
  localparam logic [LW-1:0] LED_LAST       = LW'(N_LEDS - 1);
  localparam logic [4:0]    BIT_LAST       = 5'd23;

  // Reject timing parameters that cannot produce a valid waveform.
  if (N_LEDS < 1 || T0H < 1 || T0H >= T1H || T1H >= T_BIT || RESET_CYCLES < 1) begin : g_param_check
    $error("led_strip_serializer: need N_LEDS>=1, 1<=T0H<T1H<T_BIT, RESET_CYCLES>=1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BIT   = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t                state;
  logic [N_LEDS*6-1:0]   shadow;
  logic [CW-1:0]         cyc_cnt;
  logic [4:0]            bit_cnt;
  logic [LW-1:0]         led_cnt;

  logic [5:0]            cur_code;
  logic [23:0]           cur_grb;
  logic                  cur_bit;
  logic [CW-1:0]         cur_high;
  logic [CW-1:0]         cyc_inc;

  // Each 2-bit channel is replicated four times, so the full-scale code 3
  // maps to 0xFF. The byte order on the wire is G, R, B.
  function automatic logic [23:0] expand_grb(input logic [5:0] code);
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
    g = {4{code[3:2]}};
    r = {4{code[5:4]}};
    b = {4{code[1:0]}};
    return {g, r, b};
  endfunction

  // Select the current LED code and bit, and derive that bit's high time.
  always_comb begin
    cur_code = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (led_cnt == LW'(i)) cur_code = shadow[i*6 +: 6];
    end
    cur_grb  = expand_grb(cur_code);
    cur_bit  = cur_grb[BIT_LAST - bit_cnt];
    cur_high = cur_bit ? HIGH_T1 : HIGH_T0;
    cyc_inc  = cyc_cnt + 1'b1;
  end

  // Frame sequencer: IDLE -> BIT -> LATCH -> IDLE. All outputs are registered.
  // LED_DOUT is set one cycle ahead of the counter value it belongs to. Each
  // bit slot starts high because T0H >= 1, so a new slot (including the very
  // first one) always loads a 1.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state    <= IDLE;
      shadow   <= '0;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      led_cnt  <= '0;
      LED_DOUT <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      DONE    <= 1'b0;
      OVERRUN <= START && (state != IDLE);
      case (state)
        IDLE: begin
          LED_DOUT <= 1'b0;
          if (START) begin
            shadow   <= LED_DATA;
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            led_cnt  <= '0;
            state    <= BIT;
            BUSY     <= 1'b1;
            LED_DOUT <= 1'b1;
          end
        end

        BIT: begin
          if (cyc_cnt == CYC_BIT_LAST) begin
            cyc_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (led_cnt == LED_LAST) begin
                led_cnt  <= '0;
                state    <= LATCH;
                LED_DOUT <= 1'b0;
              end else begin
                led_cnt  <= led_cnt + 1'b1;
                LED_DOUT <= 1'b1;
              end
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              LED_DOUT <= 1'b1;
            end
          end else begin
            cyc_cnt  <= cyc_inc;
            LED_DOUT <= (cyc_inc < cur_high);
          end
        end

        LATCH: begin
          LED_DOUT <= 1'b0;
          if (cyc_cnt == CYC_LATCH_LAST) begin
            cyc_cnt <= '0;
            state   <= IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
          end else begin
            cyc_cnt <= cyc_inc;
          end
        end

        default: begin
          state    <= IDLE;
          cyc_cnt  <= '0;
          bit_cnt  <= '0;
          led_cnt  <= '0;
          LED_DOUT <= 1'b0;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule
